life_sequencer: RTL and testbench

Generation sequencer for the life array. It owns the cell scan counter `cnt` that the array datapath and the cursor/editor consume, and it decides for every full sweep whether the array recirculates unchanged or loads its next generation (`evolve`). It handles run/pause, single-step and the inter-generation speed divider. It also arbitrates between evolution and pending cursor edits, so an edit is never lost under an evolving sweep.

---
 rtl/life_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_life_sequencer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_sequencer.sv
// -----------------------------------------------------------------------------
// life_sequencer
//
// Generation sequencer for the life array. Owns the cell scan counter that the
// array datapath and the cursor/editor consume, and decides per full sweep
// whether the array recirculates unchanged or loads its next generation.
// Handles run/pause, single-step, the inter-generation speed divider and the
// arbitration between evolution and pending cursor edits.
//
// Ports:
//   clk        in   clock
//   reset      in   asynchronous, active-low reset
//   run_key    in   one-cycle pulse, toggles run/pause (wins over step_key)
//   step_key   in   one-cycle pulse, request one generation while paused
//   speed      in   extra idle sweeps between generations while running
//   edit_hold  in   editor has a pending flip; blocks the start of an evolve
//   cnt        out  cell scan counter, increments every clock, wraps
//   sweep_end  out  combinational, cnt == all ones
//   evolve     out  high for every cycle of an evolving sweep
//   running    out  run mode flag
//   gen_done   out  one-cycle pulse in the cnt=0 cycle after an evolve sweep
//   gen_count  out  completed generations, wraps
//   dbg_state  out  current FSM state (0=PAUSE, 1=WAIT, 2=EVOLVE)
//
// Valid/ready: there is no handshake here. run_key/step_key are single-cycle
// strobes sampled on every rising edge; edit_hold is a level that is only
// consulted on the sweep_end edge where an evolve could start.
// -----------------------------------------------------------------------------
module life_sequencer #(
    parameter int LOG2X = 3,
    parameter int LOG2Y = 3,
    parameter int DIVW  = 8,
    parameter int GENW  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run_key,
    input  logic                   step_key,
    input  logic [DIVW-1:0]        speed,
    input  logic                   edit_hold,
    output logic [LOG2X+LOG2Y-1:0] cnt,
    output logic                   sweep_end,
    output logic                   evolve,
    output logic                   running,
    output logic                   gen_done,
    output logic [GENW-1:0]        gen_count,
    output logic [1:0]             dbg_state
);

    localparam int CW = LOG2X + LOG2Y;

    typedef enum logic [1:0] {
        ST_PAUSE  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_EVOLVE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [CW-1:0]   r_cnt;
    logic            r_running;
    logic            r_step_pend;
    logic [DIVW-1:0] r_div_cnt;
    logic            r_evolve;
    logic            r_gen_done;
    logic [GENW-1:0] r_gen_count;

    logic            w_sweep_end;
    logic            w_step_req;
    logic            w_load_div;
    logic            w_dec_div;
    logic            w_evolve_start;
    logic            w_gen_inc;

    assign w_sweep_end = &r_cnt;

    // A step_key in the sweep_end cycle itself must be serviced on that edge,
    // so the decision looks at the incoming strobe as well as the pending flag.
    // run_key in the same cycle cancels the step.
    assign w_step_req = r_step_pend | (step_key & ~run_key & ~r_running);

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_PAUSE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // --------------------------------------------------------------- next state
    // Transitions only happen on the sweep_end edge, so every state spans
    // whole sweeps.
    always_comb begin
        w_state_nxt = r_state;
        if (w_sweep_end) begin
            case (r_state)
                ST_PAUSE: begin
                    if (r_running) begin
                        w_state_nxt = ST_WAIT;
                    end else if (w_step_req && !edit_hold) begin
                        w_state_nxt = ST_EVOLVE;
                    end
                end
                ST_WAIT: begin
                    if (!r_running) begin
                        w_state_nxt = ST_PAUSE;
                    end else if (r_div_cnt == '0 && !edit_hold) begin
                        w_state_nxt = ST_EVOLVE;
                    end
                end
                ST_EVOLVE: begin
                    // edit_hold is deliberately not looked at: an evolve
                    // sweep always runs to completion.
                    if (r_running) begin
                        w_state_nxt = ST_WAIT;
                    end else begin
                        w_state_nxt = ST_PAUSE;
                    end
                end
                default: w_state_nxt = ST_PAUSE;
            endcase
        end
    end

    // ------------------------------------------------------------ output comb
    always_comb begin
        w_load_div     = 1'b0;
        w_dec_div      = 1'b0;
        w_evolve_start = 1'b0;
        w_gen_inc      = 1'b0;
        if (w_sweep_end) begin
            // speed is sampled only here, so changing it mid-WAIT has no
            // effect until the next EVOLVE/PAUSE exit.
            w_load_div     = (r_state != ST_WAIT) && (w_state_nxt == ST_WAIT);
            w_dec_div      = (r_state == ST_WAIT) && r_running && (r_div_cnt != '0);
            w_evolve_start = (r_state != ST_EVOLVE) && (w_state_nxt == ST_EVOLVE);
            w_gen_inc      = (r_state == ST_EVOLVE);
        end
    end

    // --------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_running   <= 1'b0;
            r_step_pend <= 1'b0;
            r_div_cnt   <= '0;
            r_evolve    <= 1'b0;
            r_gen_done  <= 1'b0;
            r_gen_count <= '0;
        end else begin
            r_cnt     <= r_cnt + CW'(1);
            r_running <= r_running ^ run_key;

            // A run toggle always clears a pending step: either we start
            // running (steps are meaningless) or we were running and no step
            // could have been pending.
            if (run_key) begin
                r_step_pend <= 1'b0;
            end else if (w_evolve_start) begin
                r_step_pend <= 1'b0;
            end else if (step_key && !r_running) begin
                r_step_pend <= 1'b1;
            end

            if (w_load_div) begin
                r_div_cnt <= speed;
            end else if (w_dec_div) begin
                r_div_cnt <= r_div_cnt - DIVW'(1);
            end

            r_evolve   <= (w_state_nxt == ST_EVOLVE);
            r_gen_done <= w_gen_inc;
            if (w_gen_inc) begin
                r_gen_count <= r_gen_count + GENW'(1);
            end
        end
    end

    assign cnt       = r_cnt;
    assign sweep_end = w_sweep_end;
    assign evolve    = r_evolve;
    assign running   = r_running;
    assign gen_done  = r_gen_done;
    assign gen_count = r_gen_count;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_life_sequencer.sv
module tb_life_sequencer;

    localparam int LOG2X = 3;
    localparam int LOG2Y = 3;
    localparam int DIVW  = 8;
    localparam int GENW  = 2;
    localparam int CW    = LOG2X + LOG2Y;

    localparam logic [1:0] S_PAUSE  = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_EVOLVE = 2'd2;

    logic            clk;
    logic            reset;
    logic            run_key;
    logic            step_key;
    logic [DIVW-1:0] speed;
    logic            edit_hold;
    logic [CW-1:0]   cnt;
    logic            sweep_end;
    logic            evolve;
    logic            running;
    logic            gen_done;
    logic [GENW-1:0] gen_count;
    logic [1:0]      dbg_state;

    int checks = 0;
    int errors = 0;

    life_sequencer #(
        .LOG2X(LOG2X), .LOG2Y(LOG2Y), .DIVW(DIVW), .GENW(GENW)
    ) dut (
        .clk(clk), .reset(reset), .run_key(run_key), .step_key(step_key),
        .speed(speed), .edit_hold(edit_hold), .cnt(cnt), .sweep_end(sweep_end),
        .evolve(evolve), .running(running), .gen_done(gen_done),
        .gen_count(gen_count), .dbg_state(dbg_state)
    );

    // ------------------------------------------------------- clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Leaves the bench at a negedge with reset just released and cnt == 0.
    task automatic apply_reset();
        @(negedge clk);
        reset     = 1'b0;
        run_key   = 1'b0;
        step_key  = 1'b0;
        edit_hold = 1'b0;
        speed     = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Advance at least one cycle, then until cnt == v (bounded).
    task automatic goto_cnt(input int v);
        logic [CW-1:0] target;
        int n;
        target = v[CW-1:0];
        n = 0;
        @(negedge clk);
        while (cnt !== target && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cnt !== target) begin
            errors++;
            $display("FAIL goto_cnt timeout: cnt=%0d required=%0d", cnt, target);
        end
    endtask

    task automatic pulse_run();
        run_key = 1'b1;
        @(negedge clk);
        run_key = 1'b0;
    endtask

    task automatic pulse_step();
        step_key = 1'b1;
        @(negedge clk);
        step_key = 1'b0;
    endtask

    // ------------------------------------------------------------- scenarios
    task automatic test_reset();
        int n_end;
        logic [CW-1:0] exp_cnt;
        @(negedge clk);
        reset = 1'b0;
        run_key = 1'b0; step_key = 1'b0; edit_hold = 1'b0; speed = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({cnt, evolve, running, gen_done, gen_count, dbg_state} !== '0) begin
            errors++;
            $display("FAIL reset_values: cnt=%0d ev=%b run=%b gd=%b gc=%0d st=%0d required all 0",
                     cnt, evolve, running, gen_done, gen_count, dbg_state);
        end
        reset = 1'b1;
        n_end = 0;
        exp_cnt = '0;
        for (int i = 0; i < 256; i++) begin
            checks++;
            if (cnt !== exp_cnt) begin
                errors++;
                $display("FAIL free_run_cnt: cycle %0d cnt=%0d required=%0d", i, cnt, exp_cnt);
            end
            checks++;
            if (sweep_end !== (exp_cnt == '1)) begin
                errors++;
                $display("FAIL sweep_end: cnt=%0d sweep_end=%b", exp_cnt, sweep_end);
            end
            if (sweep_end === 1'b1) n_end++;
            checks++;
            if (evolve !== 1'b0 || running !== 1'b0 || gen_count !== '0) begin
                errors++;
                $display("FAIL idle_outputs: ev=%b run=%b gc=%0d required 0,0,0",
                         evolve, running, gen_count);
            end
            exp_cnt = exp_cnt + 1'b1;
            @(negedge clk);
        end
        checks++;
        if (n_end != 4) begin
            errors++;
            $display("FAIL sweep_end_count: %0d required 4", n_end);
        end
    endtask

    task automatic test_single_step();
        logic [CW-1:0] exp_cnt;
        apply_reset();
        goto_cnt(10);
        pulse_step();
        goto_cnt(63);
        checks++;
        if (evolve !== 1'b0 || dbg_state !== S_PAUSE) begin
            errors++;
            $display("FAIL step_before: ev=%b st=%0d required 0,PAUSE", evolve, dbg_state);
        end
        @(negedge clk);
        exp_cnt = '0;
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (evolve !== 1'b1 || cnt !== exp_cnt) begin
                errors++;
                $display("FAIL step_evolve: cnt=%0d ev=%b required cnt=%0d ev=1", cnt, evolve, exp_cnt);
            end
            exp_cnt = exp_cnt + 1'b1;
            @(negedge clk);
        end
        checks++;
        if (evolve !== 1'b0 || gen_done !== 1'b1 || gen_count !== 2'd1) begin
            errors++;
            $display("FAIL step_done: ev=%b gd=%b gc=%0d required 0,1,1", evolve, gen_done, gen_count);
        end
        @(negedge clk);
        checks++;
        if (gen_done !== 1'b0) begin
            errors++;
            $display("FAIL step_gen_done_pulse: gd=%b required 0", gen_done);
        end
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (evolve !== 1'b0 || dbg_state !== S_PAUSE) begin
                errors++;
                $display("FAIL step_return_pause: ev=%b st=%0d required 0,PAUSE", evolve, dbg_state);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_run_speed();
        logic exp_ev [20] = '{0,0,0,1, 0,0,0,1, 0,0,0,1, 0,0,0,1, 0,1,0,1};
        logic [GENW-1:0] exp_gen;
        logic exp_gd;
        apply_reset();
        speed = 8'd2;
        pulse_run();
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL run_toggle: running=%b required 1", running);
        end
        exp_gen = '0;
        exp_gd  = 1'b0;
        for (int s = 0; s < 20; s++) begin
            goto_cnt(0);
            checks++;
            if (evolve !== exp_ev[s] || gen_count !== exp_gen || gen_done !== exp_gd) begin
                errors++;
                $display("FAIL run_sweep_start s=%0d: ev=%b gc=%0d gd=%b required %b,%0d,%b",
                         s, evolve, gen_count, gen_done, exp_ev[s], exp_gen, exp_gd);
            end
            if (s == 13) speed = 8'd0;
            goto_cnt(63);
            checks++;
            if (evolve !== exp_ev[s]) begin
                errors++;
                $display("FAIL run_sweep_end s=%0d: ev=%b required %b", s, evolve, exp_ev[s]);
            end
            exp_gd = exp_ev[s];
            if (exp_ev[s]) exp_gen = exp_gen + 1'b1;
        end
    endtask

    task automatic test_edit_arb();
        apply_reset();
        speed = 8'd0;
        edit_hold = 1'b1;
        pulse_run();
        for (int s = 0; s < 3; s++) begin
            goto_cnt(0);
            checks++;
            if (evolve !== 1'b0 || dbg_state !== S_WAIT) begin
                errors++;
                $display("FAIL edit_block s=%0d: ev=%b st=%0d required 0,WAIT", s, evolve, dbg_state);
            end
        end
        goto_cnt(40);
        edit_hold = 1'b0;
        goto_cnt(0);
        checks++;
        if (evolve !== 1'b1 || dbg_state !== S_EVOLVE) begin
            errors++;
            $display("FAIL edit_release: ev=%b st=%0d required 1,EVOLVE", evolve, dbg_state);
        end
        goto_cnt(5);
        edit_hold = 1'b1;
        goto_cnt(63);
        checks++;
        if (evolve !== 1'b1) begin
            errors++;
            $display("FAIL edit_during_evolve: ev=%b required 1", evolve);
        end
        goto_cnt(0);
        checks++;
        if (evolve !== 1'b0 || gen_done !== 1'b1 || gen_count !== 2'd1 || dbg_state !== S_WAIT) begin
            errors++;
            $display("FAIL edit_after_evolve: ev=%b gd=%b gc=%0d st=%0d required 0,1,1,WAIT",
                     evolve, gen_done, gen_count, dbg_state);
        end
        goto_cnt(0);
        checks++;
        if (evolve !== 1'b0 || dbg_state !== S_WAIT) begin
            errors++;
            $display("FAIL edit_block_again: ev=%b st=%0d required 0,WAIT", evolve, dbg_state);
        end
        edit_hold = 1'b0;
    endtask

    task automatic test_pause_collision();
        apply_reset();
        speed = 8'd0;
        pulse_run();
        goto_cnt(0);   // S0 WAIT
        goto_cnt(0);   // S1 EVOLVE
        goto_cnt(20);
        pulse_run();
        checks++;
        if (running !== 1'b0 || evolve !== 1'b1) begin
            errors++;
            $display("FAIL pause_mid_evolve: run=%b ev=%b required 0,1", running, evolve);
        end
        goto_cnt(63);
        checks++;
        if (evolve !== 1'b1) begin
            errors++;
            $display("FAIL pause_evolve_completes: ev=%b required 1", evolve);
        end
        goto_cnt(0);   // S2
        checks++;
        if (evolve !== 1'b0 || gen_done !== 1'b1 || gen_count !== 2'd1 || dbg_state !== S_PAUSE) begin
            errors++;
            $display("FAIL pause_after: ev=%b gd=%b gc=%0d st=%0d required 0,1,1,PAUSE",
                     evolve, gen_done, gen_count, dbg_state);
        end
        goto_cnt(0);   // S3
        checks++;
        if (evolve !== 1'b0 || dbg_state !== S_PAUSE) begin
            errors++;
            $display("FAIL pause_no_evolve: ev=%b st=%0d required 0,PAUSE", evolve, dbg_state);
        end
        goto_cnt(10);
        run_key = 1'b1;
        step_key = 1'b1;
        @(negedge clk);
        run_key = 1'b0;
        step_key = 1'b0;
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL collision_run: running=%b required 1", running);
        end
        goto_cnt(20);
        pulse_run();
        checks++;
        if (running !== 1'b0) begin
            errors++;
            $display("FAIL collision_unrun: running=%b required 0", running);
        end
        goto_cnt(0);   // S4: no step may be pending
        checks++;
        if (evolve !== 1'b0 || dbg_state !== S_PAUSE) begin
            errors++;
            $display("FAIL collision_step_dropped: ev=%b st=%0d required 0,PAUSE", evolve, dbg_state);
        end
        goto_cnt(63);
        pulse_step();  // step_key in the sweep_end cycle itself
        checks++;
        if (evolve !== 1'b1 || cnt !== '0) begin
            errors++;
            $display("FAIL step_at_sweep_end: ev=%b cnt=%0d required 1,0", evolve, cnt);
        end
        goto_cnt(30);
        pulse_step();  // step_key during EVOLVE
        goto_cnt(0);   // S6 recirculate
        checks++;
        if (evolve !== 1'b0 || gen_count !== 2'd2) begin
            errors++;
            $display("FAIL step_in_evolve_wait: ev=%b gc=%0d required 0,2", evolve, gen_count);
        end
        goto_cnt(0);   // S7 serviced
        checks++;
        if (evolve !== 1'b1) begin
            errors++;
            $display("FAIL step_in_evolve_serviced: ev=%b required 1", evolve);
        end
        goto_cnt(0);
        checks++;
        if (evolve !== 1'b0 || gen_count !== 2'd3) begin
            errors++;
            $display("FAIL step_in_evolve_done: ev=%b gc=%0d required 0,3", evolve, gen_count);
        end
    endtask

    task automatic test_wrap_async_reset();
        logic [GENW-1:0] exp_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        apply_reset();
        speed = 8'd0;
        pulse_run();
        goto_cnt(0);   // S0 WAIT
        for (int g = 0; g < 5; g++) begin
            goto_cnt(0);   // EVOLVE sweep
            goto_cnt(0);   // following WAIT sweep
            checks++;
            if (gen_count !== exp_seq[g]) begin
                errors++;
                $display("FAIL gen_wrap g=%0d: gc=%0d required %0d", g, gen_count, exp_seq[g]);
            end
        end
        goto_cnt(0);   // EVOLVE sweep
        goto_cnt(30);
        reset = 1'b0;
        #1;
        checks++;
        if ({cnt, evolve, running, gen_done, gen_count, dbg_state} !== '0) begin
            errors++;
            $display("FAIL async_reset: cnt=%0d ev=%b run=%b gd=%b gc=%0d st=%0d required all 0",
                     cnt, evolve, running, gen_done, gen_count, dbg_state);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            checks++;
            if (evolve !== 1'b0 || gen_count !== '0 || gen_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_abandon: ev=%b gc=%0d gd=%b required 0,0,0",
                         evolve, gen_count, gen_done);
            end
        end
    endtask

    // ------------------------------------------------------------------ main
    initial begin
        reset     = 1'b0;
        run_key   = 1'b0;
        step_key  = 1'b0;
        edit_hold = 1'b0;
        speed     = '0;
        test_reset();
        test_single_step();
        test_run_speed();
        test_edit_arb();
        test_pause_collision();
        test_wrap_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
